// File: rtl/memory_stage.sv
// MEM stage of the RV32 pipeline: data-memory request/ready handshake, branch/jump
// resolution and the MEM/WB pipeline register.
module memory_stage #(
  parameter int unsigned WAIT_MAX = 16
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        in_valid,
  input  logic        in_halt,
  input  logic [4:0]  in_rd,
  input  logic        in_dread,
  input  logic [1:0]  in_dwrite,
  input  logic [1:0]  in_reg_wr_src,
  input  logic        in_branch_pol,
  input  logic [1:0]  in_pc_ctrl,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rdat2,
  input  logic [31:0] in_alu_out,
  input  logic        in_alu_zero,
  input  logic [31:0] in_pc_plus_imm,
  input  logic        wb_flush,
  output logic        dmem_req,
  output logic        dmem_wen,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_strb,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        mem_stall,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        wb_valid,
  output logic        wb_halt,
  output logic        wb_err,
  output logic [4:0]  wb_rd,
  output logic [1:0]  wb_reg_wr_src,
  output logic [31:0] wb_alu_out,
  output logic [31:0] wb_mem_data,
  output logic [31:0] wb_pc_plus_4
);

  localparam int unsigned CntW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  typedef enum logic [0:0] {StIdle, StWait} state_t;

  state_t          state_q, state_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            halted_q;

  logic       live, acc, is_load, misaligned, aligned_acc, abort;
  logic       load_done, err, halt_commit;
  logic [1:0] size;

  // Reset is folded into live so no request, stall or redirect escapes while n_rst is low.
  assign live        = n_rst & in_valid & ~halted_q;
  assign is_load     = in_dread;
  assign size        = is_load ? 2'd3 : in_dwrite;
  assign acc         = live & (in_dread | (in_dwrite != 2'd0));
  assign aligned_acc = acc & ~misaligned;
  assign abort       = aligned_acc & (state_q == StWait) & ~dmem_ready &
                       (wait_cnt_q == CntW'(WAIT_MAX - 1));
  assign mem_stall   = aligned_acc & ~(dmem_ready | abort);
  assign load_done   = aligned_acc & is_load & dmem_ready;
  assign err         = acc & (misaligned | abort);
  assign halt_commit = live & in_halt & ~mem_stall & ~wb_flush;

  assign dmem_req  = aligned_acc;
  assign dmem_wen  = aligned_acc & ~is_load;
  assign dmem_addr = in_alu_out;

  always_comb begin
    misaligned = 1'b0;
    case (size)
      2'd3:    misaligned = (in_alu_out[1:0] != 2'b00);
      2'd2:    misaligned = in_alu_out[0];
      default: misaligned = 1'b0;
    endcase
  end

  always_comb begin
    dmem_strb  = 4'b0000;
    dmem_wdata = in_rdat2;
    if (!is_load) begin
      case (in_dwrite)
        2'd1: begin
          dmem_strb  = 4'b0001 << in_alu_out[1:0];
          dmem_wdata = {4{in_rdat2[7:0]}};
        end
        2'd2: begin
          dmem_strb  = in_alu_out[1] ? 4'b1100 : 4'b0011;
          dmem_wdata = {2{in_rdat2[15:0]}};
        end
        2'd3:    dmem_strb = 4'b1111;
        default: dmem_strb = 4'b0000;
      endcase
    end
  end

  always_comb begin
    redirect    = 1'b0;
    redirect_pc = in_pc_plus_imm;
    if (live && !mem_stall) begin
      case (in_pc_ctrl)
        2'd1:    redirect = in_alu_zero ^ in_branch_pol;
        2'd2:    redirect = 1'b1;
        2'd3: begin
          redirect    = 1'b1;
          redirect_pc = {in_alu_out[31:1], 1'b0};
        end
        default: redirect = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      StIdle: begin
        if (aligned_acc && !dmem_ready) begin
          state_d    = StWait;
          wait_cnt_d = '0;
        end
      end
      StWait: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        if (!aligned_acc || dmem_ready || abort) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= StIdle;
      wait_cnt_q    <= '0;
      halted_q      <= 1'b0;
      wb_valid      <= 1'b0;
      wb_halt       <= 1'b0;
      wb_err        <= 1'b0;
      wb_rd         <= '0;
      wb_reg_wr_src <= '0;
      wb_alu_out    <= '0;
      wb_mem_data   <= '0;
      wb_pc_plus_4  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (halt_commit) halted_q <= 1'b1;
      if (wb_flush || mem_stall) wb_valid <= 1'b0;
      else                       wb_valid <= live;
      wb_halt       <= in_halt;
      wb_err        <= err;
      wb_rd         <= in_rd;
      wb_reg_wr_src <= in_reg_wr_src;
      wb_alu_out    <= in_alu_out;
      wb_mem_data   <= load_done ? dmem_rdata : 32'h0;
      wb_pc_plus_4  <= in_pc + 32'd4;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: loads/stores, misalignment, timeout abort, redirects,
// halt and mid-access reset.
module tb_memory_stage;

  logic        clk, n_rst;
  logic        in_valid, in_halt, in_dread, in_branch_pol, in_alu_zero, wb_flush;
  logic [4:0]  in_rd;
  logic [1:0]  in_dwrite, in_reg_wr_src, in_pc_ctrl;
  logic [31:0] in_pc, in_rdat2, in_alu_out, in_pc_plus_imm;
  logic        dmem_req, dmem_wen, dmem_ready, mem_stall, redirect;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, redirect_pc;
  logic [3:0]  dmem_strb;
  logic        wb_valid, wb_halt, wb_err;
  logic [4:0]  wb_rd;
  logic [1:0]  wb_reg_wr_src;
  logic [31:0] wb_alu_out, wb_mem_data, wb_pc_plus_4;

  int n_checks = 0;
  int n_fail   = 0;

  memory_stage #(.WAIT_MAX(4)) dut (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_halt(in_halt), .in_rd(in_rd),
    .in_dread(in_dread), .in_dwrite(in_dwrite), .in_reg_wr_src(in_reg_wr_src),
    .in_branch_pol(in_branch_pol), .in_pc_ctrl(in_pc_ctrl), .in_pc(in_pc),
    .in_rdat2(in_rdat2), .in_alu_out(in_alu_out), .in_alu_zero(in_alu_zero),
    .in_pc_plus_imm(in_pc_plus_imm), .wb_flush(wb_flush), .dmem_req(dmem_req),
    .dmem_wen(dmem_wen), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_strb(dmem_strb), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .mem_stall(mem_stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .wb_valid(wb_valid), .wb_halt(wb_halt), .wb_err(wb_err), .wb_rd(wb_rd),
    .wb_reg_wr_src(wb_reg_wr_src), .wb_alu_out(wb_alu_out), .wb_mem_data(wb_mem_data),
    .wb_pc_plus_4(wb_pc_plus_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    in_valid = 0; in_halt = 0; in_rd = 0; in_dread = 0; in_dwrite = 0;
    in_reg_wr_src = 0; in_branch_pol = 0; in_pc_ctrl = 0; in_pc = 0; in_rdat2 = 0;
    in_alu_out = 0; in_alu_zero = 0; in_pc_plus_imm = 0; wb_flush = 0;
    dmem_rdata = 0; dmem_ready = 0;
  endtask

  task automatic set_load(input logic [31:0] addr, input logic [31:0] pc);
    set_idle();
    in_valid = 1; in_dread = 1; in_alu_out = addr; in_pc = pc; in_rd = 5'd5;
    in_reg_wr_src = 2'd1;
  endtask

  task automatic set_store(input logic [1:0] sz, input logic [31:0] addr,
                           input logic [31:0] data);
    set_idle();
    in_valid = 1; in_dwrite = sz; in_alu_out = addr; in_rdat2 = data; in_pc = 32'h50;
  endtask

  initial begin
    set_idle();
    n_rst = 0;
    #2;
    check("rst_wb_valid", wb_valid, 0);
    check("rst_dmem_req", dmem_req, 0);
    check("rst_wb_pc4", wb_pc_plus_4, 0);
    step();
    n_rst = 1;
    step();

    // 1. word load with two wait cycles
    set_load(32'h100, 32'h40);
    #1;
    check("ld_req", dmem_req, 1);
    check("ld_wen", dmem_wen, 0);
    check("ld_addr", dmem_addr, 32'h100);
    check("ld_strb", dmem_strb, 0);
    check("ld_stall0", mem_stall, 1);
    step();
    check("ld_wbv_stall0", wb_valid, 0);
    #1;
    check("ld_stall1", mem_stall, 1);
    step();
    check("ld_wbv_stall1", wb_valid, 0);
    dmem_ready = 1; dmem_rdata = 32'h12345678;
    #1;
    check("ld_stall2", mem_stall, 0);
    step();
    check("ld_wbv", wb_valid, 1);
    check("ld_data", wb_mem_data, 32'h12345678);
    check("ld_rd", wb_rd, 5);
    check("ld_pc4", wb_pc_plus_4, 32'h44);
    check("ld_err", wb_err, 0);
    set_idle();
    step();
    check("ld_wbv_once", wb_valid, 0);

    // 2. byte and half stores, zero wait
    set_store(2'd1, 32'h203, 32'hAABBCCDD);
    dmem_ready = 1;
    #1;
    check("sb_req", dmem_req, 1);
    check("sb_wen", dmem_wen, 1);
    check("sb_strb", dmem_strb, 4'b1000);
    check("sb_wdata", dmem_wdata, 32'hDDDDDDDD);
    check("sb_stall", mem_stall, 0);
    step();
    check("sb_wbv", wb_valid, 1);
    check("sb_memdata", wb_mem_data, 0);
    set_store(2'd2, 32'h202, 32'hAABBCCDD);
    dmem_ready = 1;
    #1;
    check("sh_strb", dmem_strb, 4'b1100);
    check("sh_wdata", dmem_wdata, 32'hCCDDCCDD);
    step();

    // 3. misaligned half store
    set_store(2'd2, 32'h201, 32'h1234);
    #1;
    check("mis_req", dmem_req, 0);
    check("mis_stall", mem_stall, 0);
    step();
    check("mis_err", wb_err, 1);
    check("mis_wbv", wb_valid, 1);

    // 4. timeout: 4 stall cycles then abort
    set_load(32'h300, 32'h60);
    dmem_rdata = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("to_stall%0d", i), mem_stall, 1);
      step();
    end
    #1;
    check("to_abort_stall", mem_stall, 0);
    step();
    check("to_err", wb_err, 1);
    check("to_memdata", wb_mem_data, 0);
    check("to_wbv", wb_valid, 1);
    set_idle();
    step();
    set_load(32'h304, 32'h64);
    #1;
    check("to_idle_stall", mem_stall, 1);
    step();
    dmem_ready = 1; dmem_rdata = 32'h0BADF00D;
    step();
    check("to_idle_data", wb_mem_data, 32'h0BADF00D);
    check("to_idle_err", wb_err, 0);

    // 5. redirects
    set_idle();
    in_valid = 1; in_pc_ctrl = 1; in_alu_zero = 1; in_pc_plus_imm = 32'h2000;
    #1;
    check("beq_redir", redirect, 1);
    check("beq_pc", redirect_pc, 32'h2000);
    in_branch_pol = 1;
    #1;
    check("bne_noredir", redirect, 0);
    set_idle();
    in_valid = 1; in_pc_ctrl = 3; in_alu_out = 32'h1003;
    #1;
    check("jalr_redir", redirect, 1);
    check("jalr_pc", redirect_pc, 32'h1002);
    set_idle();
    in_valid = 1; in_pc_ctrl = 2; in_pc_plus_imm = 32'h3000; in_pc = 32'hFFFFFFFC;
    in_reg_wr_src = 2'd2;
    #1;
    check("jal_pc", redirect_pc, 32'h3000);
    step();
    check("jal_pc4_wrap", wb_pc_plus_4, 0);
    check("jal_src", wb_reg_wr_src, 2);
    in_valid = 0;
    #1;
    check("bubble_noredir", redirect, 0);
    in_valid = 1; wb_flush = 1;
    step();
    check("flush_wbv", wb_valid, 0);

    // 6. halt, then reset mid-WAIT
    set_idle();
    in_valid = 1; in_halt = 1;
    step();
    check("halt_wb", wb_halt, 1);
    check("halt_wbv", wb_valid, 1);
    set_load(32'h400, 32'h70);
    #1;
    check("halted_req", dmem_req, 0);
    check("halted_stall", mem_stall, 0);
    step();
    check("halted_wbv", wb_valid, 0);
    n_rst = 0;
    step();
    n_rst = 1;
    set_load(32'h500, 32'h80);
    #1;
    check("rw_req", dmem_req, 1);
    step();
    #1;
    check("rw_stall", mem_stall, 1);
    n_rst = 0;
    #1;
    check("rw_rst_req", dmem_req, 0);
    check("rw_rst_stall", mem_stall, 0);
    check("rw_rst_wbv", wb_valid, 0);
    check("rw_rst_pc4", wb_pc_plus_4, 0);
    step();
    n_rst = 1;
    dmem_ready = 1; dmem_rdata = 32'hCAFEF00D;
    #1;
    check("rw_after_stall", mem_stall, 0);
    step();
    check("rw_after_wbv", wb_valid, 1);
    check("rw_after_data", wb_mem_data, 32'hCAFEF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
